// File: rtl/sevenseg_pkg.sv
// Shared glyph codes, FSM state and helper types for the 7-segment scan decoder.
package sevenseg_pkg;

    // Active-low {g,f,e,d,c,b,a} segment patterns
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } an_sel_t;

    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       err;
    } glyph_t;

    // Slot index of a one-hot-low anode vector; valid=0 for anything else
    function automatic an_sel_t onehot_low_idx(input logic [3:0] an);
        an_sel_t r;
        r = '0;
        case (an)
            4'b1110: begin r.valid = 1'b1; r.idx = 2'd0; end
            4'b1101: begin r.valid = 1'b1; r.idx = 2'd1; end
            4'b1011: begin r.valid = 1'b1; r.idx = 2'd2; end
            4'b0111: begin r.valid = 1'b1; r.idx = 2'd3; end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational glyph -> {nibble, blank, err} decoder.
// SEVENSEG_HEX_DECODE_EN additionally accepts the A..F glyphs.
module sevenseg_glyph_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output glyph_t     glyph_c
);

    always_comb begin
        glyph_c = '0;
        case (seg)
            GLYPH_0:     glyph_c.nibble = 4'h0;
            GLYPH_1:     glyph_c.nibble = 4'h1;
            GLYPH_2:     glyph_c.nibble = 4'h2;
            GLYPH_3:     glyph_c.nibble = 4'h3;
            GLYPH_4:     glyph_c.nibble = 4'h4;
            GLYPH_5:     glyph_c.nibble = 4'h5;
            GLYPH_6:     glyph_c.nibble = 4'h6;
            GLYPH_7:     glyph_c.nibble = 4'h7;
            GLYPH_8:     glyph_c.nibble = 4'h8;
            GLYPH_9:     glyph_c.nibble = 4'h9;
            GLYPH_BLANK: glyph_c.blank  = 1'b1;
`ifdef SEVENSEG_HEX_DECODE_EN
            GLYPH_A:     glyph_c.nibble = 4'hA;
            GLYPH_B:     glyph_c.nibble = 4'hB;
            GLYPH_C:     glyph_c.nibble = 4'hC;
            GLYPH_D:     glyph_c.nibble = 4'hD;
            GLYPH_E:     glyph_c.nibble = 4'hE;
            GLYPH_F:     glyph_c.nibble = 4'hF;
`else
            GLYPH_A, GLYPH_B, GLYPH_C,
            GLYPH_D, GLYPH_E, GLYPH_F: glyph_c.err = 1'b1;
`endif
            default:     glyph_c.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Samples a multiplexed seg/an display bus, settles each slot and commits whole 4-digit frames.
// Hex glyph acceptance is controlled by SEVENSEG_HEX_DECODE_EN (see sevenseg_glyph_decode).
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STALE_CYCLES  = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        err,
    output logic        stale
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned SW = $clog2(STALE_CYCLES + 1);

    state_t          state;
    logic [3:0]      an_q, an_p;
    logic [7:0]      seg_q, seg_p;
    logic [CW-1:0]   cnt;
    logic [3:0]      mask;
    logic [3:0][3:0] sh_nib;
    logic [3:0]      sh_dp, sh_blank, sh_err;
    logic [SW-1:0]   stale_cnt;

    an_sel_t       sel_c;
    glyph_t        glyph_c;
    logic          match_c;
    logic          capture_c;
    logic [CW-1:0] cnt_inc_c;

    sevenseg_glyph_decode u_dec (
        .seg     (seg_q[6:0]),
        .glyph_c (glyph_c)
    );

    assign sel_c   = onehot_low_idx(an_q);
    assign match_c = ({an_q, seg_q} == {an_p, seg_p});

    // Settle count after this sample, and whether the slot is captured now
    always_comb begin
        cnt_inc_c = CW'(1);
        capture_c = 1'b0;
        if (state == SETTLE && match_c)
            cnt_inc_c = cnt + CW'(1);
        if (sel_c.valid && cnt_inc_c >= CW'(SETTLE_CYCLES)) begin
            case (state)
                IDLE:     capture_c = 1'b1;
                SETTLE:   capture_c = 1'b1;
                CAPTURED: capture_c = !match_c;
                default:  capture_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            an_q        <= 4'hF;
            an_p        <= 4'hF;
            seg_q       <= 8'hFF;
            seg_p       <= 8'hFF;
            cnt         <= '0;
            mask        <= '0;
            sh_nib      <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_err      <= '0;
            stale_cnt   <= '0;
            digits      <= '0;
            dp          <= '0;
            blank       <= 4'b1111;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            stale       <= 1'b0;
        end else begin
            an_q        <= an;
            seg_q       <= seg;
            an_p        <= an_q;
            seg_p       <= seg_q;
            frame_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_c.valid) begin
                        state <= capture_c ? CAPTURED : SETTLE;
                        cnt   <= cnt_inc_c;
                    end else begin
                        cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (!sel_c.valid) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc_c;
                        if (capture_c)
                            state <= CAPTURED;
                    end
                end
                CAPTURED: begin
                    if (!sel_c.valid) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!match_c) begin
                        state <= capture_c ? CAPTURED : SETTLE;
                        cnt   <= cnt_inc_c;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            if (capture_c) begin
                sh_nib[sel_c.idx]   <= glyph_c.nibble;
                sh_dp[sel_c.idx]    <= ~seg_q[7];
                sh_blank[sel_c.idx] <= glyph_c.blank;
                sh_err[sel_c.idx]   <= glyph_c.err;
            end

            // Commit the frame the cycle after the last missing slot lands
            if (mask == 4'b1111) begin
                digits      <= sh_nib;
                dp          <= sh_dp;
                blank       <= sh_blank;
                err         <= |sh_err;
                frame_valid <= 1'b1;
            end
            mask <= ((mask == 4'b1111) ? 4'b0000 : mask)
                  | (capture_c ? (4'b0001 << sel_c.idx) : 4'b0000);

            if (capture_c) begin
                stale_cnt <= '0;
                stale     <= 1'b0;
            end else if (stale_cnt != SW'(STALE_CYCLES)) begin
                stale_cnt <= stale_cnt + SW'(1);
                stale     <= (stale_cnt + SW'(1)) == SW'(STALE_CYCLES);
            end else begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboard bench for sevenseg_scan_decoder: stimulus queues expected frames, a monitor checks commits.
module tb_sevenseg_scan_decoder;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned STALE  = 64;
`ifdef SEVENSEG_HEX_DECODE_EN
    localparam int NLEGAL = 16;
`else
    localparam int NLEGAL = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        err;
    logic        stale;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        err;
    } frame_t;

    frame_t expq[$];
    int total = 0;
    int bad   = 0;

    logic [6:0] gl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    sevenseg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .STALE_CYCLES  (STALE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .frame_valid (frame_valid),
        .err         (err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode: look the glyph up in the legal glyph table
    task automatic model_slot(input logic [6:0] g, output logic [3:0] nib,
                              output logic blk, output logic e);
        nib = 4'h0;
        blk = 1'b0;
        e   = 1'b1;
        if (g == 7'h7F) begin
            blk = 1'b1;
            e   = 1'b0;
        end else begin
            for (int v = 0; v < NLEGAL; v++)
                if (gl[v] == g) begin
                    nib = 4'(v);
                    e   = 1'b0;
                end
        end
    endtask

    // g packs slot3..slot0 glyphs, slot0 in g[6:0]; dps bit i = dp lit in slot i
    task automatic push_exp(input logic [27:0] g, input logic [3:0] dps);
        frame_t f;
        logic [3:0] nib;
        logic blk, e;
        f = '0;
        f.dp = dps;
        for (int s = 0; s < 4; s++) begin
            model_slot(g[s*7 +: 7], nib, blk, e);
            f.digits[s*4 +: 4] = nib;
            f.blank[s]         = blk;
            f.err              = f.err | e;
        end
        expq.push_back(f);
    endtask

    task automatic drive_slot(input int s, input logic [6:0] g, input logic dpb, input int hold);
        logic [3:0] one;
        one = 4'b0001;
        an  = ~(one << s);
        seg = {~dpb, g};
        repeat (hold) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [27:0] g, input logic [3:0] dps, input bit rnd);
        push_exp(g, dps);
        for (int s = 0; s < 4; s++) begin
            if (rnd && $urandom_range(3, 0) == 0)
                drive_slot(s, 7'($urandom), 1'($urandom), int'($urandom_range(2, 1)));
            drive_slot(s, g[s*7 +: 7], dps[s], rnd ? int'($urandom_range(10, 6)) : 8);
            if (rnd && $urandom_range(3, 0) == 0) begin
                an = 4'hF;
                repeat ($urandom_range(3, 1)) @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        an  = 4'hF;
        seg = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals();
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_blank", 32'(blank), 32'hF);
        chk("rst_frame_valid", 32'(frame_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);
    endtask

    function automatic logic [6:0] rand_glyph();
        int unsigned r;
        r = $urandom_range(9, 0);
        if (r <= 5)      return gl[$urandom_range(9, 0)];
        else if (r == 6) return 7'h7F;
        else if (r == 7) return 7'($urandom);
        else             return gl[$urandom_range(15, 10)];
    endfunction

    // Monitor: every commit must match the oldest outstanding expected frame
    initial begin
        frame_t e;
        forever begin
            @(negedge clk);
            if (frame_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_frame_valid", 32'(frame_valid), 32'h0);
                end else begin
                    e = expq.pop_front();
                    chk("digits", 32'(digits), 32'(e.digits));
                    chk("dp", 32'(dp), 32'(e.dp));
                    chk("blank", 32'(blank), 32'(e.blank));
                    chk("err", 32'(err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        logic [27:0] g;
        rst = 1'b1;
        an  = 4'hF;
        seg = 8'hFF;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        idle(2);

        // "1234": slot3=1 .. slot0=4
        drive_frame({gl[1], gl[2], gl[3], gl[4]}, 4'b0000, 1'b0);

        // Short glitch in slot 0 must not be captured; final glyph is 5
        push_exp({gl[8], gl[7], gl[6], gl[5]}, 4'b0000);
        drive_slot(0, gl[2], 1'b0, 2);
        drive_slot(0, gl[5], 1'b0, 8);
        drive_slot(1, gl[6], 1'b0, 8);
        drive_slot(2, gl[7], 1'b0, 8);
        drive_slot(3, gl[8], 1'b0, 8);

        // Ghosting anodes: nothing may be captured
        an  = 4'b1100;
        seg = {1'b1, gl[3]};
        repeat (10) @(negedge clk);
        drive_frame({gl[9], 7'b0101010, gl[1], gl[0]}, 4'b0000, 1'b0);

        // Blank slot 3 and decimal point on slot 1
        drive_frame({7'h7F, gl[3], gl[0], gl[7]}, 4'b0010, 1'b0);
        chk("stale_active", 32'(stale), 32'h0);

        // No captures for longer than the stale window
        idle(int'(STALE) + 10);
        chk("stale_set", 32'(stale), 32'h1);

        // Reset mid-frame
        drive_slot(0, gl[2], 1'b1, 8);
        drive_slot(1, gl[3], 1'b0, 8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        idle(2);
        drive_frame({gl[1], gl[2], gl[3], gl[4]}, 4'b1001, 1'b0);

        // Randomized frames with glitches and inter-slot gaps
        for (int i = 0; i < 24; i++) begin
            for (int s = 0; s < 4; s++)
                g[s*7 +: 7] = rand_glyph();
            drive_frame(g, 4'($urandom), 1'b1);
        end

        // Hex frame "A0F9"
        drive_frame({gl[10], gl[0], gl[15], gl[9]}, 4'b0000, 1'b0);

        idle(30);
        chk("pending_frames", 32'(expq.size()), 32'h0);
        chk("stale_end", 32'(stale), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
